// File: rtl/otter_pipe_ctrl.sv
// Hazard and valid controller for the pipelined OTTER. It tracks per-register valid/tag state and
// decodes load-use stalls, branch flushes, memory waits and EX operand forwarding selects.
module otter_pipe_ctrl #(
  parameter int          NUM_STAGES     = 5,
  parameter int          REG_AW         = 5,
  parameter logic [31:0] STALL_CNT_INIT = 32'h0,
  localparam int         NR             = NUM_STAGES - 1,
  localparam int         FW             = $clog2(NUM_STAGES)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_reg_write,
  input  logic              de_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              stall_pc,
  output logic [NR-1:0]     stall_reg,
  output logic [NR-1:0]     valid,
  output logic [FW-1:0]     fwd_a_sel,
  output logic [FW-1:0]     fwd_b_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              ld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
  } tag_t;

  tag_t        pr_q [NR];
  tag_t        pr_d [NR];
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        load_use, branch_ok, lu_stall, hold_pc;

  function automatic logic writer(tag_t t);
    return t.v && t.rw && (t.rd != '0);
  endfunction

  function automatic logic reads(logic used, logic [REG_AW-1:0] rs, logic [REG_AW-1:0] rd);
    return used && (rs != '0) && (rs == rd);
  endfunction

  // The DE instruction sits in reg 0. A load k regs ahead must keep it there until the next edge
  // brings the load into reg NR-1 exactly as the consumer enters EX, so only k up to NR-3 stalls.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load_use = 1'b0;
    for (int k = 1; k <= NR - 3; k++) begin
      if (writer(pr_q[k]) && pr_q[k].ld &&
          (reads(pr_q[0].u1, pr_q[0].rs1, pr_q[k].rd) || reads(pr_q[0].u2, pr_q[0].rs2, pr_q[k].rd)))
        load_use = 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching writer overwrites the select last.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = NR - 1; k >= 2; k--) begin
      if (writer(pr_q[k]) && reads(pr_q[1].u1, pr_q[1].rs1, pr_q[k].rd)) fwd_a_sel = FW'(k);
      if (writer(pr_q[k]) && reads(pr_q[1].u2, pr_q[1].rs2, pr_q[k].rd)) fwd_b_sel = FW'(k);
    end
  end

  assign branch_ok = ex_branch_taken && pr_q[1].v && !mem_busy;
  assign lu_stall  = load_use && !mem_busy && !branch_ok;
  assign hold_pc   = mem_busy || lu_stall;
  assign stall_pc  = hold_pc && !RESET;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_comb begin
    stall_reg = '0;
    if (!RESET) begin
      if (mem_busy)      stall_reg = {1'b0, {(NR-1){1'b1}}};
      else if (lu_stall) stall_reg[0] = 1'b1;
    end
    for (int k = 0; k < NR; k++) valid[k] = pr_q[k].v;
  end

  // A bubble is an all-zero entry so its stale sources can never drive a forward select.
  always_comb begin
    pr_d = pr_q;
    if (mem_busy) begin
      pr_d[NR-1] = '0;
    end else begin
      for (int k = NR - 1; k >= 1; k--) pr_d[k] = pr_q[k-1];
      pr_d[0].v   = 1'b1;
      pr_d[0].rd  = de_rd;
      pr_d[0].rw  = de_reg_write;
      pr_d[0].ld  = de_is_load;
      pr_d[0].rs1 = de_rs1;
      pr_d[0].rs2 = de_rs2;
      pr_d[0].u1  = de_rs1_used;
      pr_d[0].u2  = de_rs2_used;
      if (branch_ok) begin
        pr_d[0] = '0;
        pr_d[1] = '0;
      end else if (lu_stall) begin
        pr_d[0] = pr_q[0];
        pr_d[1] = '0;
      end
    end
    stall_cnt_d = (hold_pc && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (branch_ok && flush_cnt_q != 32'hFFFF_FFFF) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  // NOTE: the tag array is control state that gates stalls and forwarding, so every entry is reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NR; k++) pr_q[k] <= '0;
      stall_cnt_q <= STALL_CNT_INIT;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values of its neighbour.
      pr_q        <= pr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
